issue_select_wide: RTL and testbench
====================================

// Module: issue_select_wide
// PURPOSE
//   N-wide issue stage for the R10K core. Each cycle it selects up to ISSUE_WIDTH ready RS entries, oldest
//   first relative to the ROB head, and drives their source tags to the PRF read ports. It forwards
//   same-cycle CDB results into the operands and registers each grant into a per-lane IS/EX pipeline
//   register. Each lane has a valid/ready stall handshake. Sits between rs/prf and the execute units.
// PARAMETERS
//   RS_SIZE      8   number of RS entries presented for selection
//   ISSUE_WIDTH  2   issue lanes (1..4)
//   PREG_W       6   physical register tag width
//   SEQ_W        5   ROB-index width used for age ordering (wraps modulo 2**SEQ_W)
//   XLEN         32  operand data width
// PORTS
//   clock        in   1                     system clock, all state on posedge
//   reset        in   1                     asynchronous, active-low; 0 = reset
//   flush        in   1                     sync squash (branch mispredict)
//   rs_ready     in   RS_SIZE               entry valid and both operands ready (includes same-cycle CDB wakeup)
//   rs_seq       in   RS_SIZE*SEQ_W         ROB index of each entry
//   rs_src1      in   RS_SIZE*PREG_W        source-1 tag per entry
//   rs_src2      in   RS_SIZE*PREG_W        source-2 tag per entry
//   rs_dest      in   RS_SIZE*PREG_W        destination tag per entry
//   rob_head     in   SEQ_W                 current ROB head (oldest instruction)
//   issue_grant  out  RS_SIZE               entries issued this cycle; rs frees them at posedge
//   prf_rd_tag   out  2*ISSUE_WIDTH*PREG_W  lane i: {src2,src1} read tags
//   prf_rd_data  in   2*ISSUE_WIDTH*XLEN    combinational PRF read data, same order
//   cdb_valid    in   1                     CDB broadcast this cycle
//   cdb_tag      in   PREG_W                broadcast tag
//   cdb_data     in   XLEN                  broadcast value
//   ex_valid     out  ISSUE_WIDTH           lane register holds an instruction
//   ex_ready     in   ISSUE_WIDTH           execute unit accepts lane this cycle
//   ex_src1      out  ISSUE_WIDTH*XLEN      registered operand 1
//   ex_src2      out  ISSUE_WIDTH*XLEN      registered operand 2
//   ex_dest      out  ISSUE_WIDTH*PREG_W    registered destination tag
//   ex_seq       out  ISSUE_WIDTH*SEQ_W     registered ROB index
//   stall_cnt    out  16                    saturating count of cycles with a ready entry left unissued
// BEHAVIOUR
//   - Reset (reset==0, async): ex_valid=0; all ex_* data regs=0; stall_cnt=0. issue_grant=0 while in reset.
//   - Age: age(e) = (rs_seq[e] - rob_head) mod 2**SEQ_W. Smaller age is older. Ties go to the lower entry index.
//   - Lane free: free[i] = !ex_valid[i] | ex_ready[i].
//   - Select (combinational):
//       - Free lanes, in ascending index, take the oldest remaining rs_ready entries.
//       - A held lane (ex_valid & !ex_ready) gets no grant. Later free lanes still fill.
//       - issue_grant is the OR of the per-lane one-hots. popcount(issue_grant) <= number of free lanes.
//   - prf_rd_tag: driven from the granted entry's src tags. Lane without a grant drives 0.
//   - Forwarding: if cdb_valid and cdb_tag==src tag (tag!=0), operand = cdb_data, else prf_rd_data.
//     Tag 0 always reads 0.
//   - Latency: grant in cycle N, ex_valid[i]=1 with operands in cycle N+1.
//   - Lane register update at posedge:
//       - Granted lane: load operands, dest and seq; valid=1.
//       - Free lane with no grant: valid=0.
//       - Held lane: all fields unchanged (operands are not re-forwarded).
//   - flush=1: issue_grant forced to 0 that cycle. All ex_valid cleared at the next posedge,
//     regardless of ex_ready. stall_cnt unchanged.
//   - stall_cnt: +1 when any rs_ready bit is set that issue_grant does not cover, and flush=0.
//     Saturates at 16'hFFFF.
//   - rob_head wrap: ages are computed modulo 2**SEQ_W, so seq 31 is older than seq 1 when head=30.
//   - Async reset asserted mid-stall: lane contents are discarded immediately. No grant survives.
// TESTING
//   1 Reset: reset=0 with rs_ready=8'hFF -> issue_grant=0, ex_valid=0, stall_cnt=0.
//   2 Age order with wrap: head=30; ready entries seq {2,31,5}; ISSUE_WIDTH=2 ->
//     lane0=seq31, lane1=seq2, entry with seq5 not granted, stall_cnt+1.
//   3 Forward: entry src1=33, cdb_valid=1 tag=33 data=32'hDEAD, prf data=0 ->
//     next cycle ex_src1=32'hDEAD, ex_valid[0]=1.
//   4 Stall: lane0 held (ex_ready=2'b10) with 3 ready entries ->
//     only lane1 granted with the oldest entry; lane0 contents unchanged for 3 cycles.
//   5 Flush: both lanes valid, flush=1 and ex_ready=0 -> issue_grant=0; next cycle ex_valid=0.
//   6 Saturation: stall condition held for 70000 cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/issue_select_wide_if.sv
// Issue-stage bus: RS selection inputs, PRF read ports, CDB forwarding and per-lane IS/EX handshake.
// The issue stage connects through the slave modport and its environment through master.
interface issue_select_wide_if #(
  parameter int RS_SIZE     = 8,
  parameter int ISSUE_WIDTH = 2,
  parameter int PREG_W      = 6,
  parameter int SEQ_W       = 5,
  parameter int XLEN        = 32
);
  logic                            flush;
  logic [RS_SIZE-1:0]              rs_ready;
  logic [RS_SIZE*SEQ_W-1:0]        rs_seq;
  logic [RS_SIZE*PREG_W-1:0]       rs_src1;
  logic [RS_SIZE*PREG_W-1:0]       rs_src2;
  logic [RS_SIZE*PREG_W-1:0]       rs_dest;
  logic [SEQ_W-1:0]                rob_head;
  logic [RS_SIZE-1:0]              issue_grant;
  logic [2*ISSUE_WIDTH*PREG_W-1:0] prf_rd_tag;
  logic [2*ISSUE_WIDTH*XLEN-1:0]   prf_rd_data;
  logic                            cdb_valid;
  logic [PREG_W-1:0]               cdb_tag;
  logic [XLEN-1:0]                 cdb_data;
  logic [ISSUE_WIDTH-1:0]          ex_valid;
  logic [ISSUE_WIDTH-1:0]          ex_ready;
  logic [ISSUE_WIDTH*XLEN-1:0]     ex_src1;
  logic [ISSUE_WIDTH*XLEN-1:0]     ex_src2;
  logic [ISSUE_WIDTH*PREG_W-1:0]   ex_dest;
  logic [ISSUE_WIDTH*SEQ_W-1:0]    ex_seq;
  logic [15:0]                     stall_cnt;

  modport master (
    output flush, rs_ready, rs_seq, rs_src1, rs_src2, rs_dest, rob_head,
           prf_rd_data, cdb_valid, cdb_tag, cdb_data, ex_ready,
    input  issue_grant, prf_rd_tag, ex_valid, ex_src1, ex_src2, ex_dest, ex_seq, stall_cnt
  );

  modport slave (
    input  flush, rs_ready, rs_seq, rs_src1, rs_src2, rs_dest, rob_head,
           prf_rd_data, cdb_valid, cdb_tag, cdb_data, ex_ready,
    output issue_grant, prf_rd_tag, ex_valid, ex_src1, ex_src2, ex_dest, ex_seq, stall_cnt
  );
endinterface

// File: rtl/issue_select_wide.sv
// N-wide oldest-first issue select with CDB operand forwarding into per-lane IS/EX registers.
// Free lanes take ready RS entries in age order relative to the ROB head; held lanes keep their contents.
module issue_select_wide #(
  parameter int RS_SIZE     = 8,
  parameter int ISSUE_WIDTH = 2,
  parameter int PREG_W      = 6,
  parameter int SEQ_W       = 5,
  parameter int XLEN        = 32
) (
  input  logic              clock,
  input  logic              reset,
  issue_select_wide_if.slave bus
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  function automatic logic [XLEN-1:0] fwd_operand(input logic [PREG_W-1:0] tag,
                                                  input logic [XLEN-1:0]   prf_data,
                                                  input logic              cdb_vld,
                                                  input logic [PREG_W-1:0] cdb_t,
                                                  input logic [XLEN-1:0]   cdb_d);
    logic [XLEN-1:0] res;
    if (tag == '0)                     res = '0;
    else if (cdb_vld && cdb_t == tag) res = cdb_d;
    else                               res = prf_data;
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0: age computation, oldest-first selection, PRF tag drive and forwarding
  logic [SEQ_W-1:0]         age_p0      [RS_SIZE];
  logic [ISSUE_WIDTH-1:0]   lane_free_p0;
  logic [ISSUE_WIDTH-1:0]   lane_hit_p0;
  logic [IDX_W-1:0]         lane_idx_p0 [ISSUE_WIDTH];
  logic [RS_SIZE-1:0]       grant_p0;
  logic [PREG_W-1:0]        src1_tag_p0 [ISSUE_WIDTH];
  logic [PREG_W-1:0]        src2_tag_p0 [ISSUE_WIDTH];
  logic [PREG_W-1:0]        dest_p0     [ISSUE_WIDTH];
  logic [SEQ_W-1:0]         seq_p0      [ISSUE_WIDTH];
  logic [XLEN-1:0]          op1_p0      [ISSUE_WIDTH];
  logic [XLEN-1:0]          op2_p0      [ISSUE_WIDTH];
  logic [2*ISSUE_WIDTH*PREG_W-1:0] rd_tag_p0;
  logic                     stall_p0;

  // Stage p1: IS/EX lane registers
  logic [ISSUE_WIDTH-1:0]   vld_p1;
  logic [XLEN-1:0]          src1_p1     [ISSUE_WIDTH];
  logic [XLEN-1:0]          src2_p1     [ISSUE_WIDTH];
  logic [PREG_W-1:0]        dest_p1     [ISSUE_WIDTH];
  logic [SEQ_W-1:0]         seq_p1      [ISSUE_WIDTH];
  logic [15:0]              stall_cnt_p1;

  always_comb begin
    for (int e = 0; e < RS_SIZE; e++)
      age_p0[e] = bus.rs_seq[e*SEQ_W +: SEQ_W] - bus.rob_head;
  end

  assign lane_free_p0 = ~vld_p1 | bus.ex_ready;

  // Each free lane scans for the oldest untaken entry; strict '<' keeps ties on the lower index.
  always_comb begin
    grant_p0    = '0;
    lane_hit_p0 = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      lane_idx_p0[i] = '0;
      if (lane_free_p0[i] && reset && !bus.flush) begin
        for (int e = 0; e < RS_SIZE; e++) begin
          if (bus.rs_ready[e] && !grant_p0[e] &&
              (!lane_hit_p0[i] || age_p0[e] < age_p0[lane_idx_p0[i]])) begin
            lane_hit_p0[i] = 1'b1;
            lane_idx_p0[i] = e[IDX_W-1:0];
          end
        end
        if (lane_hit_p0[i]) grant_p0[lane_idx_p0[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_tag_p0 = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      src1_tag_p0[i] = '0;
      src2_tag_p0[i] = '0;
      dest_p0[i]     = '0;
      seq_p0[i]      = '0;
      if (lane_hit_p0[i]) begin
        src1_tag_p0[i] = bus.rs_src1[lane_idx_p0[i]*PREG_W +: PREG_W];
        src2_tag_p0[i] = bus.rs_src2[lane_idx_p0[i]*PREG_W +: PREG_W];
        dest_p0[i]     = bus.rs_dest[lane_idx_p0[i]*PREG_W +: PREG_W];
        seq_p0[i]      = bus.rs_seq[lane_idx_p0[i]*SEQ_W +: SEQ_W];
      end
      rd_tag_p0[2*i*PREG_W +: 2*PREG_W] = {src2_tag_p0[i], src1_tag_p0[i]};
      op1_p0[i] = fwd_operand(src1_tag_p0[i], bus.prf_rd_data[2*i*XLEN +: XLEN],
                              bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      op2_p0[i] = fwd_operand(src2_tag_p0[i], bus.prf_rd_data[(2*i+1)*XLEN +: XLEN],
                              bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
  end

  assign stall_p0        = |(bus.rs_ready & ~grant_p0);
  assign bus.issue_grant = grant_p0;
  assign bus.prf_rd_tag  = rd_tag_p0;

  // Stage p0 -> p1 boundary: held lanes keep their operands without re-forwarding
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1       <= '0;
      stall_cnt_p1 <= '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        src1_p1[i] <= '0;
        src2_p1[i] <= '0;
        dest_p1[i] <= '0;
        seq_p1[i]  <= '0;
      end
    end else begin
      if (!bus.flush && stall_p0) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (bus.flush) begin
          vld_p1[i] <= 1'b0;
        end else if (lane_hit_p0[i]) begin
          vld_p1[i]  <= 1'b1;
          src1_p1[i] <= op1_p0[i];
          src2_p1[i] <= op2_p0[i];
          dest_p1[i] <= dest_p0[i];
          seq_p1[i]  <= seq_p0[i];
        end else if (lane_free_p0[i]) begin
          vld_p1[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.ex_src1 = '0;
    bus.ex_src2 = '0;
    bus.ex_dest = '0;
    bus.ex_seq  = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      bus.ex_src1[i*XLEN +: XLEN]     = src1_p1[i];
      bus.ex_src2[i*XLEN +: XLEN]     = src2_p1[i];
      bus.ex_dest[i*PREG_W +: PREG_W] = dest_p1[i];
      bus.ex_seq[i*SEQ_W +: SEQ_W]    = seq_p1[i];
    end
  end

  assign bus.ex_valid  = vld_p1;
  assign bus.stall_cnt = stall_cnt_p1;
endmodule

// File: tb/tb_issue_select_wide.sv
// Directed bench for issue_select_wide: reset, wrapped age order, forwarding, stall, flush, saturation.
module tb_issue_select_wide;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  issue_select_wide_if #(.RS_SIZE(8), .ISSUE_WIDTH(2), .PREG_W(6), .SEQ_W(5), .XLEN(32)) bus();

  issue_select_wide #(.RS_SIZE(8), .ISSUE_WIDTH(2), .PREG_W(6), .SEQ_W(5), .XLEN(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic set_entry(input int e, input logic [4:0] seq, input logic [5:0] s1,
                           input logic [5:0] s2, input logic [5:0] d);
    bus.rs_seq[e*5 +: 5]  = seq;
    bus.rs_src1[e*6 +: 6] = s1;
    bus.rs_src2[e*6 +: 6] = s2;
    bus.rs_dest[e*6 +: 6] = d;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.flush = 1'b0; bus.rs_ready = 8'hFF; bus.rs_seq = '0; bus.rs_src1 = '0;
    bus.rs_src2 = '0; bus.rs_dest = '0; bus.rob_head = '0; bus.prf_rd_data = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0; bus.ex_ready = 2'b11;
    reset = 1'b0;
    #2;
    checks++; if (bus.issue_grant !== 8'h00) begin errors++; $display("FAIL reset_grant: got %h expected %h", bus.issue_grant, 8'h00); end
    next_cycle(); next_cycle();
    checks++; if (bus.issue_grant !== 8'h00) begin errors++; $display("FAIL reset_grant_held: got %h expected %h", bus.issue_grant, 8'h00); end
    checks++; if (bus.ex_valid !== 2'b00) begin errors++; $display("FAIL reset_ex_valid: got %b expected %b", bus.ex_valid, 2'b00); end
    checks++; if (bus.stall_cnt !== 16'h0000) begin errors++; $display("FAIL reset_stall_cnt: got %h expected %h", bus.stall_cnt, 16'h0000); end
    checks++; if (bus.ex_src1 !== 64'h0) begin errors++; $display("FAIL reset_ex_src1: got %h expected %h", bus.ex_src1, 64'h0); end
    bus.rs_ready = 8'h00;
    reset = 1'b1;
    next_cycle(); next_cycle();
    checks++; if (bus.stall_cnt !== 16'h0000) begin errors++; $display("FAIL idle_stall_cnt: got %h expected %h", bus.stall_cnt, 16'h0000); end
  endtask

  task automatic test_age_wrap();
    bus.rob_head = 5'd30;
    set_entry(0, 5'd2,  6'd1, 6'd2, 6'd10);
    set_entry(1, 5'd31, 6'd3, 6'd4, 6'd11);
    set_entry(2, 5'd5,  6'd5, 6'd6, 6'd12);
    bus.prf_rd_data = {32'd400, 32'd300, 32'd200, 32'd100};
    bus.rs_ready = 8'b0000_0111;
    #1;
    checks++; if (bus.issue_grant !== 8'b0000_0011) begin errors++; $display("FAIL age_grant: got %b expected %b", bus.issue_grant, 8'b0000_0011); end
    checks++; if (bus.prf_rd_tag !== {6'd2, 6'd1, 6'd4, 6'd3}) begin errors++; $display("FAIL age_rd_tag: got %h expected %h", bus.prf_rd_tag, {6'd2, 6'd1, 6'd4, 6'd3}); end
    next_cycle();
    checks++; if (bus.ex_valid !== 2'b11) begin errors++; $display("FAIL age_ex_valid: got %b expected %b", bus.ex_valid, 2'b11); end
    checks++; if (bus.ex_seq !== {5'd2, 5'd31}) begin errors++; $display("FAIL age_ex_seq: got %h expected %h", bus.ex_seq, {5'd2, 5'd31}); end
    checks++; if (bus.ex_dest !== {6'd10, 6'd11}) begin errors++; $display("FAIL age_ex_dest: got %h expected %h", bus.ex_dest, {6'd10, 6'd11}); end
    checks++; if (bus.ex_src1 !== {32'd300, 32'd100}) begin errors++; $display("FAIL age_ex_src1: got %h expected %h", bus.ex_src1, {32'd300, 32'd100}); end
    checks++; if (bus.ex_src2 !== {32'd400, 32'd200}) begin errors++; $display("FAIL age_ex_src2: got %h expected %h", bus.ex_src2, {32'd400, 32'd200}); end
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL age_stall_cnt: got %0d expected %0d", bus.stall_cnt, 1); end
    bus.rs_ready = 8'h00;
    next_cycle();
    checks++; if (bus.ex_valid !== 2'b00) begin errors++; $display("FAIL drain_ex_valid: got %b expected %b", bus.ex_valid, 2'b00); end
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL drain_stall_cnt: got %0d expected %0d", bus.stall_cnt, 1); end
  endtask

  task automatic test_forward();
    set_entry(3, 5'd0, 6'd33, 6'd7, 6'd12);
    bus.prf_rd_data = {32'h0, 32'h0, 32'h55, 32'h0};
    bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd33; bus.cdb_data = 32'hDEAD;
    bus.rs_ready = 8'b0000_1000;
    #1;
    checks++; if (bus.issue_grant !== 8'b0000_1000) begin errors++; $display("FAIL fwd_grant: got %b expected %b", bus.issue_grant, 8'b0000_1000); end
    next_cycle();
    checks++; if (bus.ex_valid !== 2'b01) begin errors++; $display("FAIL fwd_ex_valid: got %b expected %b", bus.ex_valid, 2'b01); end
    checks++; if (bus.ex_src1[31:0] !== 32'hDEAD) begin errors++; $display("FAIL fwd_ex_src1: got %h expected %h", bus.ex_src1[31:0], 32'hDEAD); end
    checks++; if (bus.ex_src2[31:0] !== 32'h55) begin errors++; $display("FAIL fwd_ex_src2_prf: got %h expected %h", bus.ex_src2[31:0], 32'h55); end
    checks++; if (bus.ex_dest[5:0] !== 6'd12) begin errors++; $display("FAIL fwd_ex_dest: got %0d expected %0d", bus.ex_dest[5:0], 12); end
    set_entry(3, 5'd0, 6'd0, 6'd9, 6'd13);
    bus.prf_rd_data = {32'h0, 32'h0, 32'h88, 32'h77};
    bus.cdb_tag = 6'd0; bus.cdb_data = 32'hBEEF;
    #1;
    checks++; if (bus.prf_rd_tag !== {12'd0, 6'd9, 6'd0}) begin errors++; $display("FAIL tag0_rd_tag: got %h expected %h", bus.prf_rd_tag, {12'd0, 6'd9, 6'd0}); end
    next_cycle();
    checks++; if (bus.ex_src1[31:0] !== 32'h0) begin errors++; $display("FAIL tag0_ex_src1: got %h expected %h", bus.ex_src1[31:0], 32'h0); end
    checks++; if (bus.ex_src2[31:0] !== 32'h88) begin errors++; $display("FAIL tag0_ex_src2: got %h expected %h", bus.ex_src2[31:0], 32'h88); end
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL fwd_stall_cnt: got %0d expected %0d", bus.stall_cnt, 1); end
    bus.cdb_valid = 1'b0; bus.rs_ready = 8'h00;
  endtask

  task automatic test_stall();
    set_entry(0, 5'd1, 6'd1, 6'd2, 6'd20);
    set_entry(1, 5'd3, 6'd3, 6'd4, 6'd21);
    bus.prf_rd_data = {32'd22, 32'd21, 32'd12, 32'd11};
    bus.ex_ready = 2'b11;
    bus.rs_ready = 8'b0000_0011;
    next_cycle();
    checks++; if (bus.ex_valid !== 2'b11) begin errors++; $display("FAIL fill_ex_valid: got %b expected %b", bus.ex_valid, 2'b11); end
    set_entry(4, 5'd10, 6'd15, 6'd16, 6'd24);
    set_entry(5, 5'd31, 6'd13, 6'd14, 6'd25);
    set_entry(6, 5'd8,  6'd17, 6'd18, 6'd26);
    bus.prf_rd_data = {32'h141, 32'h131, 32'h999, 32'h999};
    bus.ex_ready = 2'b10;
    bus.rs_ready = 8'b0111_0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.issue_grant !== 8'b0010_0000) begin errors++; $display("FAIL stall_grant[%0d]: got %b expected %b", k, bus.issue_grant, 8'b0010_0000); end
      checks++; if (bus.prf_rd_tag !== {6'd14, 6'd13, 12'd0}) begin errors++; $display("FAIL stall_rd_tag[%0d]: got %h expected %h", k, bus.prf_rd_tag, {6'd14, 6'd13, 12'd0}); end
      next_cycle();
      checks++; if (bus.ex_valid !== 2'b11) begin errors++; $display("FAIL stall_ex_valid[%0d]: got %b expected %b", k, bus.ex_valid, 2'b11); end
      checks++; if (bus.ex_seq !== {5'd31, 5'd1}) begin errors++; $display("FAIL stall_ex_seq[%0d]: got %h expected %h", k, bus.ex_seq, {5'd31, 5'd1}); end
      checks++; if (bus.ex_src1 !== {32'h131, 32'd11}) begin errors++; $display("FAIL stall_ex_src1[%0d]: got %h expected %h", k, bus.ex_src1, {32'h131, 32'd11}); end
      checks++; if (bus.ex_dest[5:0] !== 6'd20) begin errors++; $display("FAIL stall_ex_dest0[%0d]: got %0d expected %0d", k, bus.ex_dest[5:0], 20); end
      checks++; if (bus.stall_cnt !== 16'(2 + k)) begin errors++; $display("FAIL stall_cnt[%0d]: got %0d expected %0d", k, bus.stall_cnt, 2 + k); end
    end
  endtask

  task automatic test_flush();
    bus.ex_ready = 2'b00;
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.issue_grant !== 8'h00) begin errors++; $display("FAIL flush_grant: got %b expected %b", bus.issue_grant, 8'h00); end
    next_cycle();
    checks++; if (bus.ex_valid !== 2'b00) begin errors++; $display("FAIL flush_ex_valid: got %b expected %b", bus.ex_valid, 2'b00); end
    checks++; if (bus.stall_cnt !== 16'd4) begin errors++; $display("FAIL flush_stall_cnt: got %0d expected %0d", bus.stall_cnt, 4); end
    bus.flush = 1'b0;
  endtask

  task automatic test_saturation();
    bus.ex_ready = 2'b11;
    next_cycle();
    checks++; if (bus.ex_seq !== {5'd8, 5'd31}) begin errors++; $display("FAIL sat_fill_seq: got %h expected %h", bus.ex_seq, {5'd8, 5'd31}); end
    checks++; if (bus.stall_cnt !== 16'd5) begin errors++; $display("FAIL sat_fill_cnt: got %0d expected %0d", bus.stall_cnt, 5); end
    bus.ex_ready = 2'b00;
    #1;
    checks++; if (bus.issue_grant !== 8'h00) begin errors++; $display("FAIL held_grant: got %b expected %b", bus.issue_grant, 8'h00); end
    repeat (70000) @(posedge clock);
    #1;
    checks++; if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt: got %h expected %h", bus.stall_cnt, 16'hFFFF); end
    next_cycle();
    checks++; if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected %h", bus.stall_cnt, 16'hFFFF); end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.ex_valid !== 2'b00) begin errors++; $display("FAIL areset_ex_valid: got %b expected %b", bus.ex_valid, 2'b00); end
    checks++; if (bus.issue_grant !== 8'h00) begin errors++; $display("FAIL areset_grant: got %b expected %b", bus.issue_grant, 8'h00); end
    checks++; if (bus.stall_cnt !== 16'h0) begin errors++; $display("FAIL areset_stall_cnt: got %h expected %h", bus.stall_cnt, 16'h0); end
    checks++; if (bus.ex_seq !== 10'h0) begin errors++; $display("FAIL areset_ex_seq: got %h expected %h", bus.ex_seq, 10'h0); end
    next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_age_wrap();
    test_forward();
    test_stall();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
